// File: rtl/sqrt_dist_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sqrt_dist_pkg
// Brief    : Shared defaults for the sqrt formula distributor / collector pair.
//            Both sides must agree on worker count and result width.
// Revision : 1.0 - initial release
// ============================================================================
package sqrt_dist_pkg;

  // Default number of formula workers (any value >= 2 is legal)
  localparam int N_WORKERS = 8;
  // Default result width
  localparam int DATA_W    = 32;
  // Worker index width for the default worker count
  localparam int IDX_W     = $clog2(N_WORKERS);

endpackage : sqrt_dist_pkg
`default_nettype wire

// File: rtl/sqrt_result_slot.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_result_slot
// Brief    : One-entry holding register for a single worker's result. A new
//            result is accepted when the slot is empty or is being drained in
//            the same cycle; otherwise it is dropped and an overflow pulse is
//            raised for that cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sqrt_result_slot
  import sqrt_dist_pkg::*;
#(
  parameter int SLOT_W = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_i,         // worker presents a result
  input  logic [SLOT_W-1:0] wr_data_i,
  input  logic              drain_i,      // only asserted while the slot is full
  output logic              full_o,
  output logic              full_next_o,  // occupancy after this edge
  output logic [SLOT_W-1:0] data_o,
  output logic              ovf_o         // result dropped this cycle
);

  logic              full_q, full_d;
  logic [SLOT_W-1:0] data_q, data_d;
  logic              w_accept;

  // Next-state: a drain frees the entry, an accepted write (re)fills it
  always_comb begin
    w_accept = wr_i && (!full_q || drain_i);
    full_d   = full_q;
    data_d   = data_q;
    if (drain_i) begin
      full_d = 1'b0;
    end
    if (w_accept) begin
      full_d = 1'b1;
      data_d = wr_data_i;
    end
  end

  // Slot storage; contents are discarded on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o      = full_q;
  assign full_next_o = full_d;
  assign data_o      = data_q;
  // A write that finds the slot occupied and not leaving loses its data
  assign ovf_o       = wr_i && full_q && !drain_i;

endmodule : sqrt_result_slot
`default_nettype wire

// File: rtl/sqrt_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_result_collector
// Brief    : Gathers results from N round-robin formula workers, which may
//            finish out of order, and re-emits them in issue order on a
//            single registered valid/ready stream. Publishes a per-slot free
//            mask for the distributor, a full-slot count and a sticky
//            overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module sqrt_result_collector
  import sqrt_dist_pkg::*;
#(
  parameter int N_WORKERS = sqrt_dist_pkg::N_WORKERS,
  parameter int DATA_W    = sqrt_dist_pkg::DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_WORKERS-1:0]          worker_vld_i,
  input  logic [N_WORKERS*DATA_W-1:0]   worker_res_i,
  output logic                          res_vld_o,
  output logic [DATA_W-1:0]             res_o,
  input  logic                          res_rdy_i,
  output logic [N_WORKERS-1:0]          slot_free_o,
  output logic [$clog2(N_WORKERS+1)-1:0] pending_o,
  output logic                          overflow_err_o
);

  localparam int               PTR_W    = $clog2(N_WORKERS);
  localparam int               CNT_W    = $clog2(N_WORKERS+1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_WORKERS - 1);

  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic                 res_vld_q, res_vld_d;
  logic [DATA_W-1:0]    res_q, res_d;
  logic [N_WORKERS-1:0] slot_free_q;
  logic [CNT_W-1:0]     pending_q, pending_d;
  logic                 overflow_q;

  logic [N_WORKERS-1:0] w_full;
  logic [N_WORKERS-1:0] w_full_next;
  logic [N_WORKERS-1:0] w_drain;
  logic [N_WORKERS-1:0] w_ovf;
  logic [DATA_W-1:0]    w_slot_data [N_WORKERS];
  logic                 w_out_free;
  logic                 w_pop;

  // The output register can take a new result when empty or being consumed
  assign w_out_free = !res_vld_q || res_rdy_i;
  // Only the slot at rd_ptr is ever drained, which enforces issue order
  assign w_pop      = w_full[rd_ptr_q] && w_out_free;

  generate
    for (genvar i = 0; i < N_WORKERS; i++) begin : g_slot
      assign w_drain[i] = w_pop && (rd_ptr_q == PTR_W'(i));

      sqrt_result_slot #(
        .SLOT_W (DATA_W)
      ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .wr_i        (worker_vld_i[i]),
        .wr_data_i   (worker_res_i[i*DATA_W +: DATA_W]),
        .drain_i     (w_drain[i]),
        .full_o      (w_full[i]),
        .full_next_o (w_full_next[i]),
        .data_o      (w_slot_data[i]),
        .ovf_o       (w_ovf[i])
      );
    end
  endgenerate

  // Next-state for read pointer, output register and occupancy count
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    res_d     = res_q;
    res_vld_d = res_vld_q;
    pending_d = '0;
    if (w_pop) begin
      res_d     = w_slot_data[rd_ptr_q];
      res_vld_d = 1'b1;
      rd_ptr_d  = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
    end else if (res_rdy_i) begin
      res_vld_d = 1'b0;
    end
    for (int i = 0; i < N_WORKERS; i++) begin
      pending_d = pending_d + CNT_W'(w_full_next[i]);
    end
  end

  // Registered state; free mask and count are taken from the slots' next
  // occupancy so they track the slot registers without extra lag
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      res_vld_q   <= 1'b0;
      res_q       <= '0;
      slot_free_q <= '1;
      pending_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      res_vld_q   <= res_vld_d;
      res_q       <= res_d;
      slot_free_q <= ~w_full_next;
      pending_q   <= pending_d;
      overflow_q  <= overflow_q | (|w_ovf);
    end
  end

  assign res_vld_o      = res_vld_q;
  assign res_o          = res_q;
  assign slot_free_o    = slot_free_q;
  assign pending_o      = pending_q;
  assign overflow_err_o = overflow_q;

endmodule : sqrt_result_collector
`default_nettype wire

// File: tb/tb_sqrt_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_sqrt_result_collector
// Brief    : Self-checking bench for sqrt_result_collector. An N=8 and an N=5
//            instance are driven with directed sequences; a transaction-level
//            model predicts every output each cycle, and literal expectations
//            pin the emitted order and key timing points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sqrt_result_collector;

  logic clk;
  logic rst;

  // N=8 instance
  logic [7:0]     wv8;
  logic [255:0]   wr8;
  logic           rdy8, vld8, ovf8;
  logic [31:0]    res8;
  logic [7:0]     free8;
  logic [3:0]     pend8;

  // N=5 instance
  logic [4:0]     wv5;
  logic [159:0]   wr5;
  logic           rdy5, vld5, ovf5;
  logic [31:0]    res5;
  logic [4:0]     free5;
  logic [2:0]     pend5;

  int vectors     = 0;
  int miscompares = 0;
  int ecnt        = 0;
  bit armed       = 0;

  logic [31:0] log8[$];
  int          st8[$];
  logic [31:0] log5[$];

  // Model state, index 0 = N8 instance, 1 = N5 instance
  bit          mf [2][8];
  logic [31:0] md [2][8];
  int          mp [2];
  bit          mv [2];
  logic [31:0] mr [2];
  bit          mo [2];

  sqrt_result_collector #(.N_WORKERS(8), .DATA_W(32)) dut8 (
    .clk(clk), .rst(rst), .worker_vld_i(wv8), .worker_res_i(wr8),
    .res_vld_o(vld8), .res_o(res8), .res_rdy_i(rdy8),
    .slot_free_o(free8), .pending_o(pend8), .overflow_err_o(ovf8)
  );

  sqrt_result_collector #(.N_WORKERS(5), .DATA_W(32)) dut5 (
    .clk(clk), .rst(rst), .worker_vld_i(wv5), .worker_res_i(wr5),
    .res_vld_o(vld5), .res_o(res5), .res_rdy_i(rdy5),
    .slot_free_o(free5), .pending_o(pend5), .overflow_err_o(ovf5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset(int k);
    for (int i = 0; i < 8; i++) begin
      mf[k][i] = 1'b0;
      md[k][i] = '0;
    end
    mp[k] = 0;
    mv[k] = 1'b0;
    mr[k] = '0;
    mo[k] = 1'b0;
  endfunction

  // One clock of the collector at transaction level: issue-order queue of
  // per-worker mailboxes feeding a single output stage
  function automatic void model_step(int k, int n, logic [7:0] wv, logic [255:0] wr, logic rdy);
    bit pop;
    bit nf [8];
    pop = mf[k][mp[k]] && (!mv[k] || rdy);
    if (pop) begin
      mr[k] = md[k][mp[k]];
      mv[k] = 1'b1;
    end else if (rdy) begin
      mv[k] = 1'b0;
    end
    for (int i = 0; i < 8; i++) nf[i] = mf[k][i];
    if (pop) nf[mp[k]] = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (wv[i]) begin
        if (!mf[k][i] || (pop && i == mp[k])) begin
          md[k][i] = wr[i*32 +: 32];
          nf[i]    = 1'b1;
        end else begin
          mo[k] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 8; i++) mf[k][i] = nf[i];
    if (pop) mp[k] = (mp[k] + 1) % n;
  endfunction

  // Advance the model and record accepted outputs on every active edge
  always @(posedge clk) begin
    ecnt = ecnt + 1;
    if (rst) begin
      model_reset(0);
      model_reset(1);
      armed = 1'b1;
    end else begin
      if (vld8 && rdy8) begin
        log8.push_back(res8);
        st8.push_back(ecnt);
      end
      if (vld5 && rdy5) log5.push_back(res5);
      model_step(0, 8, wv8, wr8, rdy8);
      model_step(1, 5, {3'b0, wv5}, {96'b0, wr5}, rdy5);
    end
  end

  // Compare every DUT output against the model away from the active edge
  always @(negedge clk) begin
    if (armed) begin
      logic [7:0] ef8;
      logic [4:0] ef5;
      int ep8, ep5;
      ep8 = 0;
      ep5 = 0;
      for (int i = 0; i < 8; i++) begin
        ef8[i] = !mf[0][i];
        ep8 += int'(mf[0][i]);
      end
      for (int i = 0; i < 5; i++) begin
        ef5[i] = !mf[1][i];
        ep5 += int'(mf[1][i]);
      end
      chk("m8_res_vld",   vld8,  mv[0]);
      chk("m8_res",       res8,  mr[0]);
      chk("m8_slot_free", free8, ef8);
      chk("m8_pending",   pend8, ep8);
      chk("m8_overflow",  ovf8,  mo[0]);
      chk("m5_res_vld",   vld5,  mv[1]);
      chk("m5_res",       res5,  mr[1]);
      chk("m5_slot_free", free5, ef5);
      chk("m5_pending",   pend5, ep5);
      chk("m5_overflow",  ovf5,  mo[1]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    wv8 = '0;
    wv5 = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    log8.delete();
    st8.delete();
    log5.delete();
  endtask

  task automatic pulse8(input int w, input logic [31:0] v);
    wv8[w]          = 1'b1;
    wr8[w*32 +: 32] = v;
  endtask

  task automatic check_log8(input string name, input logic [31:0] exp[$]);
    chk({name, "_count"}, log8.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log8.size(); i++)
      chk(name, log8[i], exp[i]);
  endtask

  initial begin
    logic [31:0] exp[$];
    logic [4:0]  masks1[6];
    logic [4:0]  masks2[9];
    int          s, seq, nextw;

    rst = 1'b1;
    wv8 = '0; wr8 = '0; rdy8 = 1'b1;
    wv5 = '0; wr5 = '0; rdy5 = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;

    // Reset values
    chk("rst_res_vld",   vld8,  1'b0);
    chk("rst_res",       res8,  32'h0);
    chk("rst_slot_free", free8, 8'hFF);
    chk("rst_pending",   pend8, 4'd0);
    chk("rst_overflow",  ovf8,  1'b0);

    // In order: workers 0..7 return 10..17 one per cycle
    s = ecnt + 1;
    for (int i = 0; i < 8; i++) begin
      pulse8(i, 32'(10 + i));
      cyc();
    end
    repeat (6) cyc();
    exp = {};
    for (int i = 0; i < 8; i++) exp.push_back(32'(10 + i));
    check_log8("inorder", exp);
    for (int i = 0; i < st8.size(); i++) chk("inorder_cycle", st8[i], s + 2 + i);
    log8.delete(); st8.delete();

    // Out of order: 2, then 1, then 0
    s = ecnt + 1;
    pulse8(2, 32'h22); cyc();
    pulse8(1, 32'h11); cyc();
    chk("ooo_free_2_1", free8[2:1], 2'b00);
    pulse8(0, 32'h00); cyc();
    chk("ooo_free_2_1_held", free8[2:1], 2'b00);
    repeat (6) cyc();
    check_log8("ooo", '{32'h00, 32'h11, 32'h22});
    for (int i = 0; i < st8.size(); i++) chk("ooo_cycle", st8[i], s + 4 + i);

    // Backpressure with slots 0..3 written together
    do_reset();
    rdy8 = 1'b0;
    for (int i = 0; i < 4; i++) pulse8(i, 32'(32'h30 + i));
    cyc();
    chk("bp_pending_all", pend8, 4'd4);
    repeat (5) begin
      cyc();
      chk("bp_res_held", res8, 32'h30);
      chk("bp_vld_held", vld8, 1'b1);
      chk("bp_pending", pend8, 4'd3);
    end
    rdy8 = 1'b1;
    s = ecnt + 1;
    repeat (6) cyc();
    check_log8("bp", '{32'h30, 32'h31, 32'h32, 32'h33});
    for (int i = 0; i < st8.size(); i++) chk("bp_cycle", st8[i], s + i);
    chk("bp_pending_end", pend8, 4'd0);

    // Overflow: worker 3 twice while rd_ptr=0
    do_reset();
    pulse8(3, 32'hA); cyc();
    pulse8(3, 32'hB); cyc();
    chk("ovf_flag", ovf8, 1'b1);
    for (int i = 0; i < 3; i++) pulse8(i, 32'(i));
    cyc();
    repeat (8) cyc();
    check_log8("ovf", '{32'h0, 32'h1, 32'h2, 32'hA});
    chk("ovf_sticky", ovf8, 1'b1);

    // Reset mid-stream with three slots full and the output valid
    log8.delete(); st8.delete();
    rdy8 = 1'b0;
    for (int i = 4; i < 8; i++) pulse8(i, 32'(32'h40 + i));
    cyc();
    cyc();
    chk("mid_vld_before", vld8, 1'b1);
    chk("mid_pending_before", pend8, 4'd3);
    rst = 1'b1;
    cyc();
    chk("mid_rst_vld",   vld8,  1'b0);
    chk("mid_rst_res",   res8,  32'h0);
    chk("mid_rst_free",  free8, 8'hFF);
    chk("mid_rst_pend",  pend8, 4'd0);
    chk("mid_rst_ovf",   ovf8,  1'b0);
    rst = 1'b0;
    rdy8 = 1'b1;
    log8.delete(); st8.delete();
    pulse8(0, 32'h50); cyc();
    pulse8(1, 32'h51); cyc();
    repeat (6) cyc();
    check_log8("mid_restart", '{32'h50, 32'h51});

    // Wrap and refill on N=5: 20 results, write-while-drain and 4+0 together
    do_reset();
    masks1 = '{5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
    masks2 = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10001,
               5'b00010, 5'b00100, 5'b01000, 5'b10000};
    seq   = 0;
    nextw = 0;
    for (int c = 0; c < 15; c++) begin
      logic [4:0] m;
      int base;
      m = (c < 6) ? masks1[c] : 5'b0;
      if (c >= 12) m = '0;
      base = nextw;
      for (int j = 0; j < 5; j++) begin
        int w;
        w = (base + j) % 5;
        if (m[w]) begin
          wv5[w]          = 1'b1;
          wr5[w*32 +: 32] = 32'(100 + seq);
          seq++;
          nextw = (w + 1) % 5;
        end
      end
      cyc();
    end
    for (int c = 0; c < 9; c++) begin
      int base;
      base = nextw;
      for (int j = 0; j < 5; j++) begin
        int w;
        w = (base + j) % 5;
        if (masks2[c][w]) begin
          wv5[w]          = 1'b1;
          wr5[w*32 +: 32] = 32'(100 + seq);
          seq++;
          nextw = (w + 1) % 5;
        end
      end
      cyc();
    end
    repeat (8) cyc();
    chk("wrap_count", log5.size(), 20);
    for (int i = 0; i < 20 && i < log5.size(); i++) chk("wrap_order", log5[i], 32'(100 + i));
    chk("wrap_no_ovf", ovf5, 1'b0);
    chk("wrap_pending_end", pend5, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_sqrt_result_collector
`default_nettype wire
